mem_access_stage: RTL and testbench

- Memory stage of the in-order pipeline. Sits between the EX/MEM register and registers_MEMWB.
- Executes loads and stores against a request/response data-memory port. Stalls upstream while an access is outstanding.
- Produces the registered ALU/memory result, writeback controls and ROB completion pulse that registers_MEMWB captures.

---
 rtl/mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory stage of the in-order pipeline, between the EX/MEM register and
// registers_MEMWB. Non-memory ops pass through with one cycle of latency.
// Loads and stores go out on a request/response data-memory port, and
// upstream is stalled until the access completes.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   in_*                       op from EX/MEM (sampled only while idle)
//   stall                      upstream must hold its inputs
//   mem_req_*                  registered memory request (valid/ready)
//   mem_resp_valid/rdata       load response
//   out_*                      registered result for registers_MEMWB plus
//                              the one-cycle ROB completion pulse
//
// Build option
//   MEM_MISALIGN_TRAP_EN       when defined, misaligned H/W accesses issue no
//                              request and complete next cycle with
//                              out_exception = 1 (adds port out_exception).
//                              When undefined, low address bits below the
//                              access size are ignored.
module mem_access_stage #(
    parameter int ROB_IDX_W = 4,
    parameter int RD_W      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic                 in_mem_read,
    input  logic                 in_mem_write,
    input  logic [2:0]           in_funct3,
    input  logic [31:0]          in_addr,
    input  logic [31:0]          in_store_data,
    input  logic [RD_W-1:0]      in_rd,
    input  logic                 in_mem_to_reg,
    input  logic                 in_write_enable,
    input  logic [ROB_IDX_W-1:0] in_complete_idx,
    output logic                 stall,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_write,
    output logic [31:0]          mem_req_addr,
    output logic [31:0]          mem_req_wdata,
    output logic [3:0]           mem_req_wstrb,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_resp_rdata,
    output logic [31:0]          out_alu_out,
    output logic [31:0]          out_mem_out,
    output logic [RD_W-1:0]      out_rd,
    output logic                 out_mem_to_reg,
    output logic                 out_write_enable,
    output logic                 out_complete,
    output logic [ROB_IDX_W-1:0] out_complete_idx
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                 out_exception
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_RESP} state_t;

    state_t                 r_state;

    // Op captured in IDLE and used for the rest of the access
    logic                   r_is_load;
    logic [2:0]             r_funct3;
    logic [31:0]            r_addr;
    logic [RD_W-1:0]        r_rd;
    logic                   r_mem_to_reg;
    logic                   r_we;
    logic [ROB_IDX_W-1:0]   r_idx;

    logic                   r_req_valid;
    logic                   r_req_write;
    logic [31:0]            r_req_addr;
    logic [31:0]            r_req_wdata;
    logic [3:0]             r_req_wstrb;

    logic [31:0]            r_alu_out;
    logic [31:0]            r_mem_out;
    logic [RD_W-1:0]        r_out_rd;
    logic                   r_out_m2r;
    logic                   r_out_we;
    logic                   r_complete;
    logic [ROB_IDX_W-1:0]   r_out_idx;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                   r_exception;
`endif

    logic                   w_is_mem;
    logic                   w_trap;
    logic [3:0]             w_st_wstrb;
    logic [31:0]            w_st_wdata;
    logic [7:0]             w_ld_byte;
    logic [15:0]            w_ld_half;
    logic                   w_ld_sign;
    logic [31:0]            w_ld_data;

    // A load+store flag combination is treated as a load
    assign w_is_mem = in_mem_read | in_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    // funct3[1:0]: 00 byte, 01 half, otherwise word
    assign w_trap = w_is_mem &
                    ((in_funct3[1:0] == 2'b01) ? in_addr[0] :
                     (in_funct3[1] ? (|in_addr[1:0]) : 1'b0));
`else
    assign w_trap = 1'b0;
`endif

    assign stall = (r_state != ST_IDLE) | (in_valid & w_is_mem & ~w_trap);

    // Store lane placement from the live inputs (registered at capture)
    always_comb begin
        w_st_wstrb = 4'b1111;
        w_st_wdata = in_store_data;
        case (in_funct3[1:0])
            2'b00: begin
                w_st_wstrb = 4'b0001 << in_addr[1:0];
                w_st_wdata = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                w_st_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{in_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting from the captured op
    always_comb begin
        case (r_addr[1:0])
            2'b00:   w_ld_byte = mem_resp_rdata[7:0];
            2'b01:   w_ld_byte = mem_resp_rdata[15:8];
            2'b10:   w_ld_byte = mem_resp_rdata[23:16];
            default: w_ld_byte = mem_resp_rdata[31:24];
        endcase
        w_ld_half = r_addr[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
        w_ld_sign = ~r_funct3[2];
        case (r_funct3[1:0])
            2'b00:   w_ld_data = {{24{w_ld_sign & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_data = {{16{w_ld_sign & w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = mem_resp_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_is_load    <= 1'b0;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_rd         <= '0;
            r_mem_to_reg <= 1'b0;
            r_we         <= 1'b0;
            r_idx        <= '0;
            r_req_valid  <= 1'b0;
            r_req_write  <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_req_wstrb  <= '0;
            r_alu_out    <= '0;
            r_mem_out    <= '0;
            r_out_rd     <= '0;
            r_out_m2r    <= 1'b0;
            r_out_we     <= 1'b0;
            r_complete   <= 1'b0;
            r_out_idx    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_exception  <= 1'b0;
`endif
        end else begin
            // Bubble by default; payload registers hold
            r_complete <= 1'b0;
            r_out_we   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_is_mem && !w_trap) begin
                            r_state      <= ST_REQ;
                            r_is_load    <= in_mem_read;
                            r_funct3     <= in_funct3;
                            r_addr       <= in_addr;
                            r_rd         <= in_rd;
                            r_mem_to_reg <= in_mem_to_reg;
                            r_we         <= in_write_enable;
                            r_idx        <= in_complete_idx;
                            r_req_valid  <= 1'b1;
                            r_req_write  <= ~in_mem_read;
                            r_req_addr   <= {in_addr[31:2], 2'b00};
                            r_req_wstrb  <= in_mem_read ? 4'b0000 : w_st_wstrb;
                            r_req_wdata  <= in_mem_read ? 32'd0 : w_st_wdata;
                        end else begin
                            // ALU op, or trapped misaligned access
                            r_complete  <= 1'b1;
                            r_out_we    <= in_write_enable & ~w_trap;
                            r_alu_out   <= in_addr;
                            r_mem_out   <= '0;
                            r_out_rd    <= in_rd;
                            r_out_m2r   <= in_mem_to_reg;
                            r_out_idx   <= in_complete_idx;
`ifdef MEM_MISALIGN_TRAP_EN
                            r_exception <= w_trap;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        if (r_is_load) begin
                            r_state <= ST_WAIT_RESP;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_complete  <= 1'b1;
                            r_out_we    <= r_we;
                            r_alu_out   <= r_addr;
                            r_mem_out   <= '0;
                            r_out_rd    <= r_rd;
                            r_out_m2r   <= r_mem_to_reg;
                            r_out_idx   <= r_idx;
`ifdef MEM_MISALIGN_TRAP_EN
                            r_exception <= 1'b0;
`endif
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        r_state     <= ST_IDLE;
                        r_complete  <= 1'b1;
                        r_out_we    <= r_we;
                        r_alu_out   <= r_addr;
                        r_mem_out   <= w_ld_data;
                        r_out_rd    <= r_rd;
                        r_out_m2r   <= r_mem_to_reg;
                        r_out_idx   <= r_idx;
`ifdef MEM_MISALIGN_TRAP_EN
                        r_exception <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req_valid    = r_req_valid;
    assign mem_req_write    = r_req_write;
    assign mem_req_addr     = r_req_addr;
    assign mem_req_wdata    = r_req_wdata;
    assign mem_req_wstrb    = r_req_wstrb;
    assign out_alu_out      = r_alu_out;
    assign out_mem_out      = r_mem_out;
    assign out_rd           = r_out_rd;
    assign out_mem_to_reg   = r_out_m2r;
    assign out_write_enable = r_out_we;
    assign out_complete     = r_complete;
    assign out_complete_idx = r_out_idx;
`ifdef MEM_MISALIGN_TRAP_EN
    assign out_exception    = r_exception;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: random op stream against a transaction-level
// model, one negedge compare process, plus literal checks of key scenarios.
module tb_mem_access_stage;

    localparam int ROB_IDX_W = 4;
    localparam int RD_W      = 5;
    localparam int K_ALU  = 0;
    localparam int K_LD   = 1;
    localparam int K_ST   = 2;
    localparam int K_BOTH = 3;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_mem_read;
    logic                 in_mem_write;
    logic [2:0]           in_funct3;
    logic [31:0]          in_addr;
    logic [31:0]          in_store_data;
    logic [RD_W-1:0]      in_rd;
    logic                 in_mem_to_reg;
    logic                 in_write_enable;
    logic [ROB_IDX_W-1:0] in_complete_idx;
    logic                 stall;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_write;
    logic [31:0]          mem_req_addr;
    logic [31:0]          mem_req_wdata;
    logic [3:0]           mem_req_wstrb;
    logic                 mem_resp_valid;
    logic [31:0]          mem_resp_rdata;
    logic [31:0]          out_alu_out;
    logic [31:0]          out_mem_out;
    logic [RD_W-1:0]      out_rd;
    logic                 out_mem_to_reg;
    logic                 out_write_enable;
    logic                 out_complete;
    logic [ROB_IDX_W-1:0] out_complete_idx;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 out_exception;
`endif

    mem_access_stage #(.ROB_IDX_W(ROB_IDX_W), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_mem_to_reg(in_mem_to_reg), .in_write_enable(in_write_enable),
        .in_complete_idx(in_complete_idx), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .out_alu_out(out_alu_out), .out_mem_out(out_mem_out), .out_rd(out_rd),
        .out_mem_to_reg(out_mem_to_reg), .out_write_enable(out_write_enable),
        .out_complete(out_complete), .out_complete_idx(out_complete_idx)
`ifdef MEM_MISALIGN_TRAP_EN
        , .out_exception(out_exception)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Model expectations for the current cycle
    logic        exp_stall = 1'b0;
    logic        exp_req_valid = 1'b0;
    logic        exp_req_write = 1'b0;
    logic [31:0] exp_req_addr = '0;
    logic [3:0]  exp_req_wstrb = '0;
    logic [31:0] exp_req_wdata = '0;
    logic        exp_complete = 1'b0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_alu = '0;
    logic [31:0] exp_mem = '0;
    logic [RD_W-1:0] exp_rd = '0;
    logic        exp_m2r = 1'b0;
    logic [ROB_IDX_W-1:0] exp_idx = '0;
    logic        exp_exc = 1'b0;

    logic [31:0] snap_addr = '0;
    logic [31:0] snap_wdata = '0;
    logic [3:0]  snap_wstrb = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Size code from funct3[1:0]: 0 byte, 1 half, 2/3 word
    function automatic logic [31:0] fmt_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
        logic [31:0] v;
        int unsigned sh;
        if (f3[1:0] == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v  = (w >> sh) & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (f3[1:0] == 2'b01) begin
            sh = 16 * int'(a[1]);
            v  = (w >> sh) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] st_strb(logic [2:0] f3, logic [31:0] a);
        if (f3[1:0] == 2'b00) return 4'(1 << int'(a[1:0]));
        if (f3[1:0] == 2'b01) return 4'(3 << (2 * int'(a[1])));
        return 4'hF;
    endfunction

    function automatic logic [31:0] st_data(logic [2:0] f3, logic [31:0] d);
        if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h01010101;
        if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic is_trap(logic mem, logic [2:0] f3, logic [31:0] a);
        logic mis;
        mis = (f3[1:0] == 2'b01) ? (a % 2 != 0) : (f3[1] ? (a % 4 != 0) : 1'b0);
        return TRAP_EN && mem && mis;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_bubble();
        exp_complete = 1'b0;
        exp_we       = 1'b0;
    endtask

    task automatic set_done(logic [31:0] a, logic [31:0] m, logic [RD_W-1:0] rd,
                            logic m2r, logic we, logic [ROB_IDX_W-1:0] idx, logic exc);
        exp_complete = 1'b1;
        exp_we  = we;
        exp_alu = a;
        exp_mem = m;
        exp_rd  = rd;
        exp_m2r = m2r;
        exp_idx = idx;
        exp_exc = exc;
    endtask

    task automatic clear_model();
        exp_stall = 1'b0; exp_req_valid = 1'b0; exp_req_write = 1'b0;
        exp_req_addr = '0; exp_req_wstrb = '0; exp_req_wdata = '0;
        exp_complete = 1'b0; exp_we = 1'b0; exp_alu = '0; exp_mem = '0;
        exp_rd = '0; exp_m2r = 1'b0; exp_idx = '0; exp_exc = 1'b0;
    endtask

    task automatic scramble();
        in_mem_read     = 1'($urandom);
        in_mem_write    = 1'($urandom);
        in_funct3       = 3'($urandom);
        in_addr         = $urandom;
        in_store_data   = $urandom;
        in_rd           = RD_W'($urandom);
        in_mem_to_reg   = 1'($urandom);
        in_write_enable = 1'($urandom);
        in_complete_idx = ROB_IDX_W'($urandom);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            scramble();
            in_valid       = 1'b0;
            mem_req_ready  = 1'($urandom);
            mem_resp_valid = 1'($urandom);
            mem_resp_rdata = $urandom;
            exp_stall      = 1'b0;
            step();
            set_bubble();
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    // Issues one op in IDLE and plays the memory side; returns at posedge+2
    // right after the completion edge.
    task automatic run_op(int kind, logic [2:0] f3, logic [31:0] addr, logic [31:0] data,
                          logic [RD_W-1:0] rd, logic m2r, logic we,
                          logic [ROB_IDX_W-1:0] idx, int rdy_dly, int rsp_dly,
                          logic [31:0] rdata);
        logic mem, ld, trap;
        mem  = (kind != K_ALU);
        ld   = (kind == K_LD) || (kind == K_BOTH);
        trap = is_trap(mem, f3, addr);
        in_valid        = 1'b1;
        in_mem_read     = ld;
        in_mem_write    = (kind == K_ST) || (kind == K_BOTH);
        in_funct3       = f3;
        in_addr         = addr;
        in_store_data   = data;
        in_rd           = rd;
        in_mem_to_reg   = m2r;
        in_write_enable = we;
        in_complete_idx = idx;
        mem_req_ready   = 1'b0;
        mem_resp_valid  = 1'b0;
        exp_stall       = mem && !trap;
        step();
        if (!mem || trap) begin
            set_done(addr, 32'd0, rd, m2r, trap ? 1'b0 : we, idx, trap);
        end else begin
            set_bubble();
            exp_stall     = 1'b1;
            exp_req_valid = 1'b1;
            exp_req_write = !ld;
            exp_req_addr  = addr & 32'hFFFF_FFFC;
            exp_req_wstrb = st_strb(f3, addr);
            exp_req_wdata = st_data(f3, data);
            for (int i = 0; i < rdy_dly; i++) begin
                scramble();
                in_valid       = 1'($urandom);
                mem_resp_valid = 1'($urandom);
                mem_resp_rdata = $urandom;
                step();
            end
            scramble();
            in_valid       = 1'($urandom);
            mem_req_ready  = 1'b1;
            mem_resp_valid = 1'($urandom);
            mem_resp_rdata = $urandom;
            snap_addr  = mem_req_addr;
            snap_wstrb = mem_req_wstrb;
            snap_wdata = mem_req_wdata;
            step();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            exp_req_valid  = 1'b0;
            if (!ld) begin
                set_done(addr, 32'd0, rd, m2r, we, idx, 1'b0);
            end else begin
                for (int i = 0; i < rsp_dly; i++) begin
                    scramble();
                    in_valid      = 1'($urandom);
                    mem_req_ready = 1'($urandom);
                    step();
                end
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_rdata = rdata;
                step();
                mem_resp_valid = 1'b0;
                set_done(addr, fmt_load(f3, addr, rdata), rd, m2r, we, idx, 1'b0);
            end
        end
        scramble();
        in_valid  = 1'b0;
        exp_stall = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("req_valid", 32'(mem_req_valid), 32'(exp_req_valid));
        if (exp_req_valid) begin
            chk("req_write", 32'(mem_req_write), 32'(exp_req_write));
            chk("req_addr", mem_req_addr, exp_req_addr);
            if (exp_req_write) begin
                chk("req_wstrb", 32'(mem_req_wstrb), 32'(exp_req_wstrb));
                chk("req_wdata", mem_req_wdata, exp_req_wdata);
            end
        end
        chk("complete", 32'(out_complete), 32'(exp_complete));
        chk("write_enable", 32'(out_write_enable), 32'(exp_we));
        chk("alu_out", out_alu_out, exp_alu);
        chk("mem_out", out_mem_out, exp_mem);
        chk("rd", 32'(out_rd), 32'(exp_rd));
        chk("mem_to_reg", 32'(out_mem_to_reg), 32'(exp_m2r));
        chk("complete_idx", 32'(out_complete_idx), 32'(exp_idx));
`ifdef MEM_MISALIGN_TRAP_EN
        chk("exception", 32'(out_exception), 32'(exp_exc));
`endif
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        logic [2:0] f3;
        logic [2:0] ld_f3 [5];
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
        ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

        reset = 1'b1;
        scramble();
        in_valid       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        repeat (3) step();
        chk("rst_complete", 32'(out_complete), 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        reset = 1'b0;
        idle(2);

        // ALU op
        run_op(K_ALU, 3'b000, 32'h1234, 32'd0, 5'd5, 1'b0, 1'b1, 4'd3, 0, 0, 32'd0);
        chk("alu_complete", 32'(out_complete), 32'd1);
        chk("alu_out_lit", out_alu_out, 32'h1234);
        chk("alu_we_lit", 32'(out_write_enable), 32'd1);
        chk("alu_idx_lit", 32'(out_complete_idx), 32'd3);

        // LB with 2-cycle ready delay
        run_op(K_LD, 3'b000, 32'h103, 32'd0, 5'd7, 1'b1, 1'b1, 4'd4, 2, 1, 32'h80AABBCC);
        chk("lb_req_addr", snap_addr, 32'h100);
        chk("lb_data", out_mem_out, 32'hFFFFFF80);

        // LHU
        run_op(K_LD, 3'b101, 32'h102, 32'd0, 5'd8, 1'b1, 1'b1, 4'd5, 0, 0, 32'h8001FFFF);
        chk("lhu_data", out_mem_out, 32'h00008001);

        // SB
        run_op(K_ST, 3'b000, 32'h201, 32'h12345678, 5'd0, 1'b0, 1'b0, 4'd6, 1, 0, 32'd0);
        chk("sb_wstrb", 32'(snap_wstrb), 32'h2);
        chk("sb_wdata", snap_wdata, 32'h78787878);
        chk("sb_complete", 32'(out_complete), 32'd1);

        // Randomized op stream
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == K_ST) f3 = 3'($urandom_range(0, 2));
            else if (kind == K_ALU) f3 = 3'($urandom);
            else f3 = ld_f3[$urandom_range(0, 4)];
            run_op(kind, f3, $urandom, $urandom, RD_W'($urandom), 1'($urandom),
                   1'($urandom), ROB_IDX_W'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end

        // Reset while waiting for a load response, then a stray response
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
        in_funct3 = 3'b010; in_addr = 32'h40; in_write_enable = 1'b1;
        exp_stall = 1'b1;
        step();
        set_bubble();
        in_valid = 1'b0;
        exp_req_valid = 1'b1; exp_req_write = 1'b0; exp_req_addr = 32'h40;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        exp_req_valid = 1'b0;
        reset = 1'b1;
        clear_model();
        step();
        reset = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEADBEEF;
        step();
        mem_resp_valid = 1'b0;
        step();
        chk("rst_mid_complete", 32'(out_complete), 32'd0);
        chk("rst_mid_mem_out", out_mem_out, 32'd0);
        chk("rst_mid_req_valid", 32'(mem_req_valid), 32'd0);
        idle(1);

`ifdef MEM_MISALIGN_TRAP_EN
        run_op(K_LD, 3'b010, 32'h102, 32'd0, 5'd9, 1'b1, 1'b1, 4'd2, 0, 0, 32'd0);
        chk("trap_exception", 32'(out_exception), 32'd1);
        chk("trap_complete", 32'(out_complete), 32'd1);
        chk("trap_we", 32'(out_write_enable), 32'd0);
        idle(1);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
